// File: rtl/fiber_evt_pkg.sv
// rtl/fiber_evt_pkg.sv - shared state encoding, trailer defaults and trailer match
package fiber_evt_pkg;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;

  localparam logic [31:0] DEF_TRL_MASK = 32'h00F0_0000;
  localparam logic [31:0] DEF_TRL_VAL  = 32'h0010_0000;

  // Operands are zero-extended by the caller so one function serves any DW up to 64.
  function automatic logic trl_match(input logic [63:0] w,
                                     input logic [63:0] mask,
                                     input logic [63:0] val);
    return (w & mask) == val;
  endfunction

endpackage

// File: rtl/evt_rr_arbiter.sv
// rtl/evt_rr_arbiter.sv - combinational round-robin grant starting at ptr_i
module evt_rr_arbiter #(
  parameter int NCH = 2,
  parameter int AW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req_i,
  input  logic [AW-1:0]  ptr_i,
  output logic [AW-1:0]  grant_o,
  output logic           any_req_o
);

  int idx;

  // Scan from the farthest offset down so the closest requester at/after ptr_i wins.
  always_comb begin
    grant_o   = '0;
    any_req_o = 1'b0;
    idx       = 0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = (int'(ptr_i) + k) % NCH;
      if (req_i[idx]) begin
        grant_o   = AW'(idx);
        any_req_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fiber_evt_block_mux.sv
// rtl/fiber_evt_block_mux.sv - round-robin block forwarder from NCH event FIFOs to the Aurora FIFO
module fiber_evt_block_mux
  import fiber_evt_pkg::*;
#(
  parameter int            NCH       = 2,
  parameter int            DW        = 32,
  parameter logic [DW-1:0] TRL_MASK  = DW'(DEF_TRL_MASK),
  parameter logic [DW-1:0] TRL_VAL   = DW'(DEF_TRL_VAL),
  parameter int            MAX_WORDS = 4096,
  localparam int           AW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              CLK,
  input  logic              RSTb,
  input  logic              ENABLE,
  input  logic [NCH*DW-1:0] IN_FIFO_DATA,
  input  logic [NCH-1:0]    IN_FIFO_EMPTY,
  output logic [NCH-1:0]    IN_FIFO_RD,
  input  logic              OUT_FIFO_FULL,
  output logic              OUT_FIFO_WR,
  output logic [DW-1:0]     OUT_FIFO_DATA,
  output logic              OUT_FIFO_END,
  input  logic              ERR_CLR,
  output logic              TRUNC_ERR,
  output logic [15:0]       BLOCK_COUNT,
  output logic [AW-1:0]     ACTIVE_CH,
  output logic              BUSY
);

  localparam int CW = $clog2(MAX_WORDS);

  state_e        state_q;
  logic [AW-1:0] active_q, rr_q, rr_d, grant;
  logic [CW-1:0] wcnt_q;
  logic          wr_q, end_q, err_q, any_req;
  logic [DW-1:0] data_q, word;
  logic [15:0]   cnt_q;
  logic          go, is_trl, end_w;

  evt_rr_arbiter #(.NCH(NCH), .AW(AW)) u_arb (
    .req_i     (~IN_FIFO_EMPTY),
    .ptr_i     (rr_q),
    .grant_o   (grant),
    .any_req_o (any_req)
  );

  assign word   = IN_FIFO_DATA[int'(active_q)*DW +: DW];
  assign go     = (state_q == XFER) && !IN_FIFO_EMPTY[active_q] && !OUT_FIFO_FULL;
  assign is_trl = trl_match(64'(word), 64'(TRL_MASK), 64'(TRL_VAL));
  // The word at the MAX_WORDS-1 count closes the block whether or not it is a trailer.
  assign end_w  = is_trl || (wcnt_q == CW'(MAX_WORDS - 1));
  assign rr_d   = AW'((int'(active_q) + 1) % NCH);

  always_comb begin
    IN_FIFO_RD = '0;
    if (go) IN_FIFO_RD[active_q] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      state_q  <= IDLE;
      active_q <= '0;
      rr_q     <= '0;
      wcnt_q   <= '0;
      wr_q     <= 1'b0;
      end_q    <= 1'b0;
      data_q   <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      wr_q  <= go;
      end_q <= go && end_w;
      if (go) begin
        data_q <= word;
        wcnt_q <= wcnt_q + CW'(1);
      end
      if (go && end_w && !is_trl) err_q <= 1'b1;
      else if (ERR_CLR)           err_q <= 1'b0;
      case (state_q)
        IDLE: if (ENABLE && any_req) begin
          active_q <= grant;
          wcnt_q   <= '0;
          state_q  <= XFER;
        end
        XFER: if (go && end_w) state_q <= DONE;
        DONE: begin
          cnt_q   <= cnt_q + 16'd1;
          rr_q    <= rr_d;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign OUT_FIFO_WR   = wr_q;
  assign OUT_FIFO_DATA = data_q;
  assign OUT_FIFO_END  = end_q;
  assign TRUNC_ERR     = err_q;
  assign BLOCK_COUNT   = cnt_q;
  assign ACTIVE_CH     = active_q;
  assign BUSY          = (state_q != IDLE);

endmodule

// File: tb/tb_fiber_evt_block_mux.sv
// tb/tb_fiber_evt_block_mux.sv - self-checking bench for fiber_evt_block_mux
module tb_fiber_evt_block_mux;

  localparam int NCH = 2, DW = 32, MAXW = 4;

  logic              CLK = 1'b0;
  logic              RSTb, ENABLE, OUT_FIFO_FULL, ERR_CLR;
  logic [NCH*DW-1:0] IN_FIFO_DATA;
  logic [NCH-1:0]    IN_FIFO_EMPTY, IN_FIFO_RD;
  logic              OUT_FIFO_WR, OUT_FIFO_END, TRUNC_ERR, BUSY;
  logic [DW-1:0]     OUT_FIFO_DATA;
  logic [15:0]       BLOCK_COUNT;
  logic [0:0]        ACTIVE_CH;

  always #5 CLK = ~CLK;

  fiber_evt_block_mux #(.NCH(NCH), .DW(DW), .MAX_WORDS(MAXW)) dut (
    .CLK(CLK), .RSTb(RSTb), .ENABLE(ENABLE),
    .IN_FIFO_DATA(IN_FIFO_DATA), .IN_FIFO_EMPTY(IN_FIFO_EMPTY), .IN_FIFO_RD(IN_FIFO_RD),
    .OUT_FIFO_FULL(OUT_FIFO_FULL), .OUT_FIFO_WR(OUT_FIFO_WR), .OUT_FIFO_DATA(OUT_FIFO_DATA),
    .OUT_FIFO_END(OUT_FIFO_END), .ERR_CLR(ERR_CLR), .TRUNC_ERR(TRUNC_ERR),
    .BLOCK_COUNT(BLOCK_COUNT), .ACTIVE_CH(ACTIVE_CH), .BUSY(BUSY)
  );

  logic [31:0] q0[$], q1[$];
  logic [31:0] wr_d[$];
  bit          wr_e[$];
  int          wr_c[$], wr_cyc[$], rd_cyc[$];
  int          cyc = 0, viol = 0, pass_n = 0, total_n = 0;
  bit          prev_full = 1'b0, prev_rd = 1'b0;
  logic [NCH-1:0] rd_s;

  function automatic bit is_trl(input logic [31:0] w);
    return (w & 32'h00F0_0000) == 32'h0010_0000;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic refresh();
    IN_FIFO_EMPTY[0]      = (q0.size() == 0);
    IN_FIFO_EMPTY[1]      = (q1.size() == 0);
    IN_FIFO_DATA[31:0]    = (q0.size() != 0) ? q0[0] : 32'h0;
    IN_FIFO_DATA[63:32]   = (q1.size() != 0) ? q1[0] : 32'h0;
  endtask

  always @(posedge CLK) cyc++;

  // FWFT input FIFOs: pop on an accepted read, head visible combinationally.
  always begin
    refresh();
    @(posedge CLK);
    rd_s = IN_FIFO_RD;
    #1;
    if (rd_s[0]) begin if (q0.size() != 0) void'(q0.pop_front()); else viol++; end
    if (rd_s[1]) begin if (q1.size() != 0) void'(q1.pop_front()); else viol++; end
    refresh();
    @(negedge CLK);
    #1;
  end

  always begin
    @(negedge CLK);
    #2;
    if (OUT_FIFO_FULL && (|IN_FIFO_RD)) viol++;
    if (OUT_FIFO_WR && (prev_full || !prev_rd)) viol++;
    if (|IN_FIFO_RD) rd_cyc.push_back(cyc);
    if (OUT_FIFO_WR) begin
      wr_d.push_back(OUT_FIFO_DATA);
      wr_e.push_back(OUT_FIFO_END);
      wr_c.push_back(int'(ACTIVE_CH));
      wr_cyc.push_back(cyc);
    end
    prev_full = OUT_FIFO_FULL;
    prev_rd   = |IN_FIFO_RD;
  end

  task automatic clr_logs();
    wr_d.delete(); wr_e.delete(); wr_c.delete(); wr_cyc.delete(); rd_cyc.delete();
    viol = 0;
  endtask

  task automatic push(input int ch, input logic [31:0] w);
    if (ch == 0) q0.push_back(w); else q1.push_back(w);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RSTb = 1'b0; ENABLE = 1'b0; ERR_CLR = 1'b0; OUT_FIFO_FULL = 1'b0;
    q0.delete(); q1.delete();
    @(negedge CLK);
    RSTb = 1'b1;
    clr_logs();
  endtask

  task automatic wait_idle(input string nm, input int bound);
    int k = 0;
    do begin @(negedge CLK); k++; end
    while (!(q0.size() == 0 && q1.size() == 0 && !BUSY) && k < bound);
    if (k >= bound) chk({nm, " timeout"}, 1, 0);
  endtask

  typedef struct {
    int ch; int n; bit last_trl;
    int exp_wr; int exp_blk; bit exp_err;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int k, n, bc0;
    logic [31:0] w;
    logic [31:0] sent[$];
    logic [31:0] m0[$], m1[$];
    logic [31:0] ed[$];
    bit          ee[$];
    int          ec[$];
    int          ptr, ch, ne, eblk;
    bit          eerr;

    tbl[0] = '{0, 3, 1, 3, 1, 0};
    tbl[1] = '{1, 1, 1, 1, 1, 0};
    tbl[2] = '{1, 4, 1, 4, 1, 0};
    tbl[3] = '{0, 4, 0, 4, 1, 1};
    tbl[4] = '{1, 5, 1, 5, 2, 1};
    tbl[5] = '{0, 8, 0, 8, 2, 1};

    RSTb = 1'b0; ENABLE = 1'b0; ERR_CLR = 1'b0; OUT_FIFO_FULL = 1'b0;
    repeat (2) @(negedge CLK);
    RSTb = 1'b1;
    chk("rst wr", OUT_FIFO_WR, 0);
    chk("rst end", OUT_FIFO_END, 0);
    chk("rst data", OUT_FIFO_DATA, 0);
    chk("rst cnt", BLOCK_COUNT, 0);
    chk("rst busy", BUSY, 0);
    chk("rst err", TRUNC_ERR, 0);
    chk("rst ach", ACTIVE_CH, 0);
    chk("rst rd", IN_FIFO_RD, 0);

    // Three-word block with one-cycle read-to-write latency.
    do_reset();
    push(0, 32'h0000_00A1); push(0, 32'h0000_00A2); push(0, 32'h0010_0003);
    ENABLE = 1'b1;
    wait_idle("blk3", 50);
    chk("blk3 n", wr_d.size(), 3);
    if (wr_d.size() == 3 && rd_cyc.size() == 3) begin
      chk("blk3 d0", wr_d[0], 32'h0000_00A1);
      chk("blk3 d1", wr_d[1], 32'h0000_00A2);
      chk("blk3 d2", wr_d[2], 32'h0010_0003);
      chk("blk3 ends", {wr_e[0], wr_e[1], wr_e[2]}, 3'b001);
      for (int i = 0; i < 3; i++) chk("blk3 lat", wr_cyc[i] - rd_cyc[i], 1);
      chk("blk3 back2back", rd_cyc[2] - rd_cyc[0], 2);
    end
    chk("blk3 cnt", BLOCK_COUNT, 1);
    chk("blk3 ach", ACTIVE_CH, 0);
    chk("blk3 viol", viol, 0);

    // Round-robin over two channels of one-word blocks.
    do_reset();
    push(0, 32'h0010_0001); push(0, 32'h0010_0001);
    push(1, 32'h0010_0002); push(1, 32'h0010_0002);
    ENABLE = 1'b1;
    wait_idle("rr", 80);
    chk("rr n", wr_d.size(), 4);
    if (wr_d.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("rr ch", wr_c[i], i % 2);
        chk("rr data", wr_d[i], (i % 2) ? 32'h0010_0002 : 32'h0010_0001);
      end
      chk("rr gap", wr_cyc[1] - wr_cyc[0], 3);
    end
    chk("rr cnt", BLOCK_COUNT, 4);

    // Output full for five cycles in the middle of a block.
    clr_logs();
    push(0, 32'h0000_00B1); push(0, 32'h0000_00B2); push(0, 32'h0000_00B3); push(0, 32'h0010_0004);
    k = 0;
    do begin @(negedge CLK); k++; end while (!OUT_FIFO_WR && k < 50);
    OUT_FIFO_FULL = 1'b1;
    repeat (5) @(negedge CLK);
    OUT_FIFO_FULL = 1'b0;
    wait_idle("full", 80);
    chk("full n", wr_d.size(), 4);
    if (wr_d.size() == 4) begin
      chk("full data", {wr_d[0], wr_d[1], wr_d[2], wr_d[3]} == {32'hB1, 32'hB2, 32'hB3, 32'h0010_0004}, 1);
      chk("full ends", {wr_e[0], wr_e[1], wr_e[2], wr_e[3]}, 4'b0001);
      chk("full stall", wr_cyc[1] - wr_cyc[0], 6);
    end
    chk("full viol", viol, 0);

    // Runaway block truncated at MAX_WORDS; remainder becomes the next block.
    clr_logs();
    bc0 = BLOCK_COUNT;
    for (int i = 1; i <= 6; i++) push(0, 32'h0000_00C0 + i);
    k = 0;
    do begin @(negedge CLK); k++; end while (wr_d.size() < 6 && k < 100);
    chk("trunc n", wr_d.size(), 6);
    if (wr_d.size() == 6) begin
      for (int i = 0; i < 6; i++) chk("trunc data", wr_d[i], 32'h0000_00C1 + i);
      chk("trunc ends", {wr_e[0], wr_e[1], wr_e[2], wr_e[3], wr_e[4], wr_e[5]}, 6'b000100);
    end
    chk("trunc err", TRUNC_ERR, 1);
    chk("trunc cnt", BLOCK_COUNT - bc0, 1);
    push(0, 32'h0010_0007);
    wait_idle("trunc rest", 50);
    chk("rest n", wr_d.size(), 7);
    if (wr_d.size() == 7) chk("rest end", wr_e[6], 1);
    chk("rest cnt", BLOCK_COUNT - bc0, 2);
    chk("rest err sticky", TRUNC_ERR, 1);
    @(negedge CLK); ERR_CLR = 1'b1;
    @(negedge CLK); ERR_CLR = 1'b0;
    chk("errclr", TRUNC_ERR, 0);

    // ERR_CLR in the same cycle as a truncating read: set wins.
    clr_logs();
    for (int i = 1; i <= 4; i++) push(1, 32'h0000_00D0 + i);
    n = 0; k = 0;
    while (n < 4 && k < 60) begin
      @(negedge CLK); k++;
      if (|IN_FIFO_RD) n++;
    end
    ERR_CLR = 1'b1;
    @(negedge CLK); ERR_CLR = 1'b0;
    chk("setwins", TRUNC_ERR, 1);
    wait_idle("setwins", 30);
    @(negedge CLK); ERR_CLR = 1'b1;
    @(negedge CLK); ERR_CLR = 1'b0;

    // ENABLE dropped mid-block; trailer landing exactly on the last allowed word.
    clr_logs();
    push(1, 32'h0000_00E1); push(1, 32'h0000_00E2); push(1, 32'h0000_00E3); push(1, 32'h0010_0008);
    k = 0;
    do begin @(negedge CLK); k++; end while (!OUT_FIFO_WR && k < 50);
    ENABLE = 1'b0;
    wait_idle("endrop", 50);
    chk("endrop n", wr_d.size(), 4);
    if (wr_d.size() == 4) chk("endrop ends", {wr_e[0], wr_e[1], wr_e[2], wr_e[3]}, 4'b0001);
    chk("endrop noerr", TRUNC_ERR, 0);
    push(0, 32'h0010_0009);
    repeat (10) @(negedge CLK);
    chk("endrop hold n", wr_d.size(), 4);
    chk("endrop hold busy", BUSY, 0);
    chk("endrop hold q", q0.size(), 1);
    ENABLE = 1'b1;
    wait_idle("endrop resume", 50);
    chk("endrop resume n", wr_d.size(), 5);

    // Synchronous reset mid-block, then an asynchronous glitch that must be ignored.
    clr_logs();
    push(0, 32'h0000_00F1); push(0, 32'h0000_00F2); push(0, 32'h0000_00F3); push(0, 32'h0010_000A);
    n = 0; k = 0;
    while (n < 2 && k < 50) begin
      @(negedge CLK); k++;
      if (OUT_FIFO_WR) n++;
    end
    RSTb = 1'b0; ENABLE = 1'b0;
    @(negedge CLK);
    RSTb = 1'b1;
    chk("mrst wr", OUT_FIFO_WR, 0);
    chk("mrst end", OUT_FIFO_END, 0);
    chk("mrst data", OUT_FIFO_DATA, 0);
    chk("mrst cnt", BLOCK_COUNT, 0);
    chk("mrst busy", BUSY, 0);
    chk("mrst rd", IN_FIFO_RD, 0);
    chk("mrst norewind", q0.size(), 1);
    clr_logs();
    OUT_FIFO_FULL = 1'b1; ENABLE = 1'b1;
    repeat (3) @(negedge CLK);
    chk("glitch pre busy", BUSY, 1);
    #2 RSTb = 1'b0;
    #2 RSTb = 1'b1;
    @(negedge CLK);
    chk("glitch busy", BUSY, 1);
    OUT_FIFO_FULL = 1'b0;
    wait_idle("glitch", 30);
    chk("glitch cnt", BLOCK_COUNT, 1);
    chk("glitch n", wr_d.size(), 1);
    if (wr_d.size() == 1) chk("glitch word", {wr_e[0], wr_d[0]}, {1'b1, 32'h0010_000A});

    // Table of single-channel scenarios.
    for (int t = 0; t < 6; t++) begin
      @(negedge CLK); ERR_CLR = 1'b1;
      @(negedge CLK); ERR_CLR = 1'b0;
      clr_logs();
      sent.delete();
      bc0 = BLOCK_COUNT;
      for (int i = 0; i < tbl[t].n; i++) begin
        w = (tbl[t].last_trl && i == tbl[t].n - 1) ? (32'h0010_0000 | (t << 8) | i)
                                                   : (32'h00A0_0000 | (t << 8) | i);
        push(tbl[t].ch, w);
        sent.push_back(w);
      end
      wait_idle("tbl", 100);
      chk("tbl writes", wr_d.size(), tbl[t].exp_wr);
      chk("tbl blocks", BLOCK_COUNT - bc0, tbl[t].exp_blk);
      chk("tbl err", TRUNC_ERR, tbl[t].exp_err);
      n = 0;
      foreach (wr_e[i]) n += wr_e[i];
      chk("tbl endcount", n, tbl[t].exp_blk);
      chk("tbl data", wr_d == sent, 1);
    end

    // Randomized rounds against a block-level round-robin model.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      m0.delete(); m1.delete();
      for (int c = 0; c < 2; c++) begin
        for (int b = 0; b < $urandom_range(1, 4); b++) begin
          ne = $urandom_range(1, 6);
          for (int i = 0; i < ne; i++) begin
            w = $urandom;
            w[23:20] = ((i == ne - 1) && ($urandom_range(0, 9) < 7)) ? 4'h1 : 4'h5;
            push(c, w);
            if (c == 0) m0.push_back(w); else m1.push_back(w);
          end
        end
        w = $urandom; w[23:20] = 4'h1;
        push(c, w);
        if (c == 0) m0.push_back(w); else m1.push_back(w);
      end
      ed.delete(); ee.delete(); ec.delete();
      ptr = 0; eblk = 0; eerr = 0;
      while (m0.size() != 0 || m1.size() != 0) begin
        ch = (ptr == 0) ? ((m0.size() != 0) ? 0 : 1) : ((m1.size() != 0) ? 1 : 0);
        ne = 0;
        forever begin
          w = (ch == 0) ? m0.pop_front() : m1.pop_front();
          ne++;
          ed.push_back(w); ec.push_back(ch);
          if (is_trl(w) || ne == MAXW) begin
            ee.push_back(1'b1);
            if (!is_trl(w)) eerr = 1;
            break;
          end
          ee.push_back(1'b0);
          if ((ch == 0 ? m0.size() : m1.size()) == 0) break;
        end
        eblk++;
        ptr = (ch + 1) % 2;
      end
      ENABLE = 1'b1;
      k = 0;
      do begin
        @(negedge CLK); k++;
        OUT_FIFO_FULL = ($urandom_range(0, 9) < 3);
      end while (!(q0.size() == 0 && q1.size() == 0 && !BUSY) && k < 3000);
      OUT_FIFO_FULL = 1'b0;
      if (k >= 3000) chk("rand timeout", 1, 0);
      repeat (2) @(negedge CLK);
      chk("rand n", wr_d.size(), ed.size());
      if (wr_d.size() == ed.size()) begin
        for (int i = 0; i < ed.size(); i++) begin
          chk("rand word", {wr_e[i], wr_d[i]}, {ee[i], ed[i]});
          chk("rand ch", wr_c[i], ec[i]);
        end
      end
      chk("rand blocks", BLOCK_COUNT, eblk);
      chk("rand err", TRUNC_ERR, eerr);
      chk("rand viol", viol, 0);
    end

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule

// File: doc/fiber_evt_block_mux.md
Name: fiber_evt_block_mux

Overview:
- Multi-channel successor to the single-channel fiber event forwarder.
- Arbitrates round-robin among NCH first-word-fall-through event FIFOs and forwards whole blocks, header to block trailer, into the Aurora output FIFO.
- Marks the trailer word with OUT_FIFO_END and truncates runaway blocks at MAX_WORDS.
- Maintains a block counter and a sticky truncation error for the fiber status registers.

Parameters:
- NCH, 2, number of input event FIFOs (1..8).
- DW, 32, data word width.
- TRL_MASK, 32'h00F0_0000, bits compared for trailer detection.
- TRL_VAL, 32'h0010_0000, trailer pattern: word[23:20]==4'b0001, 24-bit format.
- MAX_WORDS, 4096, maximum words per block, trailer included (≥2).

Ports:
- CLK  in  1  system clock.
- RSTb  in  1  reset, synchronous, active-low.
- ENABLE  in  1  permits starting a new block (FIBER_CHANNEL_UP & enable).
- IN_FIFO_DATA  in  NCH*DW  FWFT data; channel i at [i*DW +: DW].
- IN_FIFO_EMPTY  in  NCH  per-channel empty.
- IN_FIFO_RD  out  NCH  per-channel read strobe.
- OUT_FIFO_FULL  in  1  Aurora FIFO full; asserted with ≥1 free entry remaining.
- OUT_FIFO_WR  out  1  write strobe.
- OUT_FIFO_DATA  out  DW  write data.
- OUT_FIFO_END  out  1  end-of-block flag, qualified by OUT_FIFO_WR.
- ERR_CLR  in  1  clears TRUNC_ERR.
- TRUNC_ERR  out  1  sticky: a block was truncated at MAX_WORDS.
- BLOCK_COUNT  out  16  blocks completed, wraps.
- ACTIVE_CH  out  max(1,$clog2(NCH))  channel being forwarded.
- BUSY  out  1  high outside IDLE.

Behaviour:
- Reset (RSTb=0 at a CLK edge):
  - All outputs 0; state IDLE; round-robin pointer 0; word counter 0.
  - A reset mid-block abandons the block: no END is written, and the partially read input FIFO is not rewound.
- Reset and ERR_CLR are the only clears.
- trailer(w) = ((w & TRL_MASK) == TRL_VAL).
- States:
  - IDLE: if ENABLE and any ~IN_FIFO_EMPTY, the arbiter grants the first non-empty channel at or after rr_ptr, modulo NCH. Latch ACTIVE_CH=grant, clear word counter, go to XFER. No read occurs in the IDLE cycle.
  - XFER: the combinational read is go = ~IN_FIFO_EMPTY[ACTIVE_CH] & ~OUT_FIFO_FULL, giving IN_FIFO_RD[ACTIVE_CH] = go; all other bits are 0.
    - On go, register OUT_FIFO_DATA = word and OUT_FIFO_WR = 1 on the next edge. Write latency is 1 cycle after read.
    - On go, END = trailer(word) | (wcnt == MAX_WORDS-1). Register OUT_FIFO_END = END alongside OUT_FIFO_WR, and wcnt increments.
    - If END: if the cause is not trailer(word), set TRUNC_ERR. Go to DONE.
    - Empty or full simply stalls XFER, which holds state with no timeout.
    - ENABLE deasserting during XFER does not stop the block; it completes.
  - DONE (1 cycle): BLOCK_COUNT+1 (wraps 16'hFFFF→0); rr_ptr = ACTIVE_CH+1 mod NCH; go to IDLE.
- Throughput: one word per cycle while data is present and there is room. There is a minimum 2-cycle gap between blocks (DONE, IDLE).
- OUT_FIFO_WR is 0 in every cycle not preceded by a go.
- ERR_CLR concurrent with a new truncation: the set wins.
- Trailer arriving exactly at wcnt==MAX_WORDS-1: this is a normal end, with no error.
- Truncation: the remainder of the runaway block stays in the input FIFO. The next grant of that channel treats the remainder as a new block.

Decomposition:
- Package fiber_evt_pkg:
  - state enum {IDLE, XFER, DONE};
  - default TRL_MASK/TRL_VAL;
  - the trailer-match function.
- One sub-module, evt_rr_arbiter: parameter NCH; inputs req[NCH], ptr; outputs grant index and any_req. Purely combinational priority rotation.

Test Plan:
- NCH=2; ch0 holds 3 words 0x000000A1, 0x000000A2, 0x00100003 → writes A1, A2, then 0x00100003 with END=1, on consecutive cycles 1 cycle after each RD.
  - BLOCK_COUNT=1; ACTIVE_CH=0; then IDLE.
- Both channels hold 1-word trailer blocks (0x00100001, 0x00100002) from reset:
  - order ch0, ch1, ch0, ch1;
  - BLOCK_COUNT=4.
- OUT_FIFO_FULL held high for 5 cycles mid-block → no RD and no WR during those cycles; the block resumes with data intact and no duplicate words.
- MAX_WORDS=4; ch0 holds 6 non-trailer words → 4 written, the 4th with END=1; TRUNC_ERR=1.
  - Next grant forwards the remaining 2 words.
  - ERR_CLR pulse → TRUNC_ERR=0.
- ENABLE dropped after the 1st word of a 4-word block → all 4 words are written with END. No new block starts while ENABLE=0.
- RSTb=0 for 1 cycle mid-block:
  - the next cycle has all outputs 0, state IDLE, BLOCK_COUNT=0;
  - an async reset pulse between edges has no effect.
